cache_miss_engine: RTL and testbench

- Per-cache miss handler that runs after a lookup miss: optional dirty-victim writeback, then line fill from higher memory over a valid/ready request channel.
- Generalises the fixed down-counter miss recovery to critical-word-first wrap ordering, parametrised line/word geometry and a split request/response handshake.
- Sits between the cache controller FSM, the data array and the hmem memory interface.

---
 rtl/cache_miss_engine_pkg.sv | 17 +
 rtl/miss_addr_gen.sv | 82 ++++++++
 rtl/cache_miss_engine.sv | 167 ++++++++++++++++
 tb/tb_cache_miss_engine.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_miss_engine_pkg.sv
// Shared types and helpers for the cache miss engine and its address generator.
package cache_miss_engine_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWbReq,
    StFillReq,
    StFillWait,
    StDone
  } miss_engine_state_e;

  // Next word index within a line, wrapping from words-1 back to 0.
  function automatic int unsigned word_index_wrap(int unsigned idx, int unsigned words);
    return (idx + 32'd1 >= words) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/miss_addr_gen.sv
// Block/word-index registers for the miss engine; forms the word-aligned request
// address for both the writeback and fill phases.
module miss_addr_gen
  import cache_miss_engine_pkg::*;
#(
  parameter int unsigned XLEN                = 32,
  parameter int unsigned LINE_SIZE           = 32,
  parameter int unsigned CRITICAL_WORD_FIRST = 1,
  localparam int unsigned WORDS              = LINE_SIZE / 4,
  localparam int unsigned OFS                = $clog2(LINE_SIZE),
  localparam int unsigned WSEL               = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                load_i,
  input  logic [XLEN-1:0]     fill_addr_i,
  input  logic [XLEN-OFS-1:0] victim_block_i,
  input  logic                wb_adv_i,
  input  logic                fill_adv_i,
  input  logic                wb_sel_i,
  input  logic                addr_en_i,
  output logic [XLEN-1:0]     addr_o,
  output logic [WSEL-1:0]     wb_idx_o,
  output logic [WSEL-1:0]     fill_idx_o,
  output logic                wb_last_o
);

  logic [XLEN-OFS-1:0] fill_block_q, fill_block_d;
  logic [XLEN-OFS-1:0] victim_block_q, victim_block_d;
  logic [WSEL-1:0]     wb_idx_q, wb_idx_d;
  logic [WSEL-1:0]     fill_idx_q, fill_idx_d;
  logic [WSEL-1:0]     crit;
  logic [XLEN-1:0]     sel_block;
  logic [WSEL-1:0]     sel_idx;

  // Masking with WORDS-1 keeps the index at 0 for single-word lines.
  assign crit = (CRITICAL_WORD_FIRST != 0) ?
                WSEL'((fill_addr_i >> 2) & XLEN'(WORDS - 1)) : '0;

  always_comb begin
    fill_block_d   = fill_block_q;
    victim_block_d = victim_block_q;
    wb_idx_d       = wb_idx_q;
    fill_idx_d     = fill_idx_q;
    if (load_i) begin
      fill_block_d   = (XLEN-OFS)'(fill_addr_i >> OFS);
      victim_block_d = victim_block_i;
      wb_idx_d       = '0;
      fill_idx_d     = crit;
    end else begin
      if (wb_adv_i) begin
        wb_idx_d = WSEL'(word_index_wrap(32'(wb_idx_q), WORDS));
      end
      if (fill_adv_i) begin
        fill_idx_d = WSEL'(word_index_wrap(32'(fill_idx_q), WORDS));
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      fill_block_q   <= '0;
      victim_block_q <= '0;
      wb_idx_q       <= '0;
      fill_idx_q     <= '0;
    end else begin
      fill_block_q   <= fill_block_d;
      victim_block_q <= victim_block_d;
      wb_idx_q       <= wb_idx_d;
      fill_idx_q     <= fill_idx_d;
    end
  end

  assign sel_block = wb_sel_i ? XLEN'(victim_block_q) : XLEN'(fill_block_q);
  assign sel_idx   = wb_sel_i ? wb_idx_q : fill_idx_q;
  assign addr_o    = addr_en_i ? ((sel_block << OFS) | (XLEN'(sel_idx) << 2)) : '0;

  assign wb_idx_o   = wb_idx_q;
  assign fill_idx_o = fill_idx_q;
  assign wb_last_o  = (wb_idx_q == WSEL'(WORDS - 1));

endmodule

// File: rtl/cache_miss_engine.sv
// Cache miss handler: optional dirty-victim writeback, then critical-word-first line fill.
// Define CACHE_MISS_ENGINE_LATENCY_STATS_EN to add miss-latency statistics outputs.
module cache_miss_engine
  import cache_miss_engine_pkg::*;
#(
  parameter int unsigned XLEN                = 32,
  parameter int unsigned LINE_SIZE           = 32,
  parameter int unsigned CRITICAL_WORD_FIRST = 1,
  parameter int unsigned READ_ONLY           = 0,
  localparam int unsigned WORDS              = LINE_SIZE / 4,
  localparam int unsigned OFS                = $clog2(LINE_SIZE),
  localparam int unsigned WSEL               = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [XLEN-1:0]     fill_addr,
  input  logic [XLEN-OFS-1:0] victim_block,
  input  logic                victim_dirty,
  output logic                busy,
  output logic                done,
  output logic                hmem_req_valid,
  input  logic                hmem_req_ready,
  output logic                hmem_req_write,
  output logic [XLEN-1:0]     hmem_req_address,
  output logic [XLEN-1:0]     hmem_req_store_word,
  input  logic                hmem_rsp_valid,
  input  logic [XLEN-1:0]     hmem_rsp_word,
  output logic [WSEL-1:0]     line_rd_index,
  input  logic [XLEN-1:0]     line_rd_word,
  output logic                line_wr_en,
  output logic [WSEL-1:0]     line_wr_index,
  output logic [XLEN-1:0]     line_wr_word,
  output logic                critical_valid,
  output logic [XLEN-1:0]     critical_word,
  output logic                count_writeback
`ifdef CACHE_MISS_ENGINE_LATENCY_STATS_EN
  ,
  output logic [XLEN-1:0]     last_miss_cycles,
  output logic [XLEN-1:0]     max_miss_cycles
`endif
);

  localparam int unsigned BW = $clog2(WORDS + 1);

  if (XLEN != 32) begin : g_bad_xlen
    $error("cache_miss_engine: XLEN must be 32");
  end
  if (LINE_SIZE < 4 || (LINE_SIZE & (LINE_SIZE - 1)) != 0) begin : g_bad_line
    $error("cache_miss_engine: LINE_SIZE must be a power of two of at least 4");
  end

  miss_engine_state_e state_q;
  logic [BW-1:0]      beat_q;

  logic            load, wb_st, fill_req_st, fill_wait_st;
  logic            wb_hs, fill_beat, wb_last;
  logic [WSEL-1:0] wb_idx, fill_idx;

  assign load         = (state_q == StIdle) && start;
  assign wb_st        = (state_q == StWbReq);
  assign fill_req_st  = (state_q == StFillReq);
  assign fill_wait_st = (state_q == StFillWait);
  assign wb_hs        = wb_st && hmem_req_ready;
  assign fill_beat    = fill_wait_st && hmem_rsp_valid;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      beat_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            beat_q  <= '0;
            state_q <= (victim_dirty && READ_ONLY == 0) ? StWbReq : StFillReq;
          end
        end
        StWbReq: begin
          if (hmem_req_ready && wb_last) state_q <= StFillReq;
        end
        StFillReq: begin
          if (hmem_req_ready) state_q <= StFillWait;
        end
        StFillWait: begin
          if (hmem_rsp_valid) begin
            beat_q  <= beat_q + 1'b1;
            state_q <= (beat_q == BW'(WORDS - 1)) ? StDone : StFillReq;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  miss_addr_gen #(
    .XLEN                (XLEN),
    .LINE_SIZE           (LINE_SIZE),
    .CRITICAL_WORD_FIRST (CRITICAL_WORD_FIRST)
  ) u_addr_gen (
    .clk_i          (clk),
    .reset_ni       (reset_n),
    .load_i         (load),
    .fill_addr_i    (fill_addr),
    .victim_block_i (victim_block),
    .wb_adv_i       (wb_hs),
    .fill_adv_i     (fill_beat),
    .wb_sel_i       (wb_st),
    .addr_en_i      (hmem_req_valid),
    .addr_o         (hmem_req_address),
    .wb_idx_o       (wb_idx),
    .fill_idx_o     (fill_idx),
    .wb_last_o      (wb_last)
  );

  // Data-carrying outputs are gated so everything reads 0 outside its phase.
  assign busy                = (state_q != StIdle);
  assign done                = (state_q == StDone);
  assign hmem_req_valid      = wb_st || fill_req_st;
  assign hmem_req_write      = (READ_ONLY == 0) && wb_st;
  assign hmem_req_store_word = wb_st ? line_rd_word : '0;
  assign line_rd_index       = wb_st ? wb_idx : '0;
  assign line_wr_en          = fill_beat;
  assign line_wr_index       = fill_beat ? fill_idx : '0;
  assign line_wr_word        = fill_beat ? hmem_rsp_word : '0;
  assign critical_valid      = fill_beat && (beat_q == '0);
  assign critical_word       = critical_valid ? hmem_rsp_word : '0;
  assign count_writeback     = wb_hs && wb_last;

`ifdef CACHE_MISS_ENGINE_LATENCY_STATS_EN
  logic [XLEN-1:0] lat_cnt_q, lat_cnt_d;
  logic [XLEN-1:0] last_q, last_d;
  logic [XLEN-1:0] max_q, max_d;

  always_comb begin
    lat_cnt_d = lat_cnt_q;
    last_d    = last_q;
    max_d     = max_q;
    if (load) begin
      lat_cnt_d = '0;
    end else if (busy && lat_cnt_q != '1) begin
      lat_cnt_d = lat_cnt_q + 1'b1;
    end
    if (done) begin
      last_d = lat_cnt_q;
      if (lat_cnt_q > max_q) max_d = lat_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lat_cnt_q <= '0;
      last_q    <= '0;
      max_q     <= '0;
    end else begin
      lat_cnt_q <= lat_cnt_d;
      last_q    <= last_d;
      max_q     <= max_d;
    end
  end

  assign last_miss_cycles = last_q;
  assign max_miss_cycles  = max_q;
`endif

endmodule

// File: tb/tb_cache_miss_engine.sv
// Directed bench for cache_miss_engine: one default instance plus one with
// critical-word-first disabled, sharing the memory-side stimulus.
module tb_cache_miss_engine;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_a, start_b;
  logic [31:0] fill_addr;
  logic [26:0] victim_block;
  logic        victim_dirty;
  logic        hmem_req_ready;
  logic        hmem_rsp_valid;
  logic [31:0] hmem_rsp_word;
  logic [31:0] line_rd_word;

  logic        a_busy, a_done, a_valid, a_write, a_wr_en, a_crit_valid, a_count_wb;
  logic [31:0] a_addr, a_store, a_wr_word, a_crit_word;
  logic [2:0]  a_rd_idx, a_wr_idx;
  logic        b_busy, b_done, b_valid, b_write, b_wr_en, b_crit_valid, b_count_wb;
  logic [31:0] b_addr, b_store, b_wr_word, b_crit_word;
  logic [2:0]  b_rd_idx, b_wr_idx;
`ifdef CACHE_MISS_ENGINE_LATENCY_STATS_EN
  logic [31:0] a_last_cyc, a_max_cyc, b_last_cyc, b_max_cyc;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cache_miss_engine u_dut_a (
    .clk                 (clk),
    .reset_n             (reset_n),
    .start               (start_a),
    .fill_addr           (fill_addr),
    .victim_block        (victim_block),
    .victim_dirty        (victim_dirty),
    .busy                (a_busy),
    .done                (a_done),
    .hmem_req_valid      (a_valid),
    .hmem_req_ready      (hmem_req_ready),
    .hmem_req_write      (a_write),
    .hmem_req_address    (a_addr),
    .hmem_req_store_word (a_store),
    .hmem_rsp_valid      (hmem_rsp_valid),
    .hmem_rsp_word       (hmem_rsp_word),
    .line_rd_index       (a_rd_idx),
    .line_rd_word        (line_rd_word),
    .line_wr_en          (a_wr_en),
    .line_wr_index       (a_wr_idx),
    .line_wr_word        (a_wr_word),
    .critical_valid      (a_crit_valid),
    .critical_word       (a_crit_word),
    .count_writeback     (a_count_wb)
`ifdef CACHE_MISS_ENGINE_LATENCY_STATS_EN
    ,
    .last_miss_cycles    (a_last_cyc),
    .max_miss_cycles     (a_max_cyc)
`endif
  );

  cache_miss_engine #(
    .CRITICAL_WORD_FIRST (0)
  ) u_dut_b (
    .clk                 (clk),
    .reset_n             (reset_n),
    .start               (start_b),
    .fill_addr           (fill_addr),
    .victim_block        (victim_block),
    .victim_dirty        (victim_dirty),
    .busy                (b_busy),
    .done                (b_done),
    .hmem_req_valid      (b_valid),
    .hmem_req_ready      (hmem_req_ready),
    .hmem_req_write      (b_write),
    .hmem_req_address    (b_addr),
    .hmem_req_store_word (b_store),
    .hmem_rsp_valid      (hmem_rsp_valid),
    .hmem_rsp_word       (hmem_rsp_word),
    .line_rd_index       (b_rd_idx),
    .line_rd_word        (line_rd_word),
    .line_wr_en          (b_wr_en),
    .line_wr_index       (b_wr_idx),
    .line_wr_word        (b_wr_word),
    .critical_valid      (b_crit_valid),
    .critical_word       (b_crit_word),
    .count_writeback     (b_count_wb)
`ifdef CACHE_MISS_ENGINE_LATENCY_STATS_EN
    ,
    .last_miss_cycles    (b_last_cyc),
    .max_miss_cycles     (b_max_cyc)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start_a        = 1'b0;
    start_b        = 1'b0;
    victim_dirty   = 1'b0;
    hmem_req_ready = 1'b1;
    hmem_rsp_valid = 1'b0;
    hmem_rsp_word  = 32'h0;
  endtask

  task automatic test_reset();
    logic [139:0] got;
    clear_inputs();
    reset_n      = 1'b0;
    start_a      = 1'b1;
    start_b      = 1'b1;
    fill_addr    = 32'h1014;
    victim_block = 27'h7F;
    line_rd_word = 32'hDEAD_BEEF;
    tick();
    tick();
    #1;
    got = {a_busy, a_done, a_valid, a_write, a_addr, a_store, a_rd_idx, a_wr_en, a_wr_idx,
           a_wr_word, a_crit_valid, a_crit_word, a_count_wb};
    n_checks++;
    if (got !== '0) $display("FAIL reset_a: got %h, want 0", got);
    else n_pass++;
    got = {b_busy, b_done, b_valid, b_write, b_addr, b_store, b_rd_idx, b_wr_en, b_wr_idx,
           b_wr_word, b_crit_valid, b_crit_word, b_count_wb};
    n_checks++;
    if (got !== '0) $display("FAIL reset_b: got %h, want 0", got);
    else n_pass++;
    clear_inputs();
    reset_n = 1'b1;
    tick();
  endtask

  // Zero-wait fill of line 0x1000, critical word 5: addresses 0x1014.. wrap to 0x1010.
  task automatic test_clean_fill();
    logic [41:0] got, exp;
    logic [31:0] ea;
    logic [2:0]  ei;
    logic        ev, ew;
    clear_inputs();
    fill_addr = 32'h1014;
    start_a   = 1'b1;
    tick();
    for (int c = 1; c <= 18; c++) begin
      clear_inputs();
      hmem_rsp_valid = (c % 2 == 0) && (c <= 16);
      hmem_rsp_word  = 32'hA000_0000 + 32'(c);
      #1;
      ev  = (c % 2 == 1) && (c <= 15);
      ea  = ev ? 32'h1000 + 32'((((5 + (c - 1) / 2) % 8)) * 4) : 32'h0;
      ew  = hmem_rsp_valid;
      ei  = ew ? 3'((5 + c / 2 - 1) % 8) : 3'd0;
      exp = {c <= 17, c == 17, ev, 1'b0, ea, ew, ei, c == 2, 1'b0};
      got = {a_busy, a_done, a_valid, a_write, a_addr, a_wr_en, a_wr_idx, a_crit_valid,
             a_count_wb};
      n_checks++;
      if (got !== exp) $display("FAIL clean_fill c=%0d: got %h, want %h", c, got, exp);
      else n_pass++;
      if (c == 2) begin
        n_checks++;
        if (a_crit_word !== 32'hA000_0002)
          $display("FAIL critical_word: got %h, want a0000002", a_crit_word);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_no_cwf();
    logic [40:0] got, exp;
    logic [31:0] ea;
    logic [2:0]  ei;
    logic        ev, ew;
    int          n_a_wr = 0;
    clear_inputs();
    fill_addr = 32'h1014;
    start_b   = 1'b1;
    tick();
    for (int c = 1; c <= 18; c++) begin
      clear_inputs();
      hmem_rsp_valid = (c % 2 == 0) && (c <= 16);
      hmem_rsp_word  = 32'hB000_0000 + 32'(c);
      #1;
      ev  = (c % 2 == 1) && (c <= 15);
      ea  = ev ? 32'h1000 + 32'(((c - 1) / 2) * 4) : 32'h0;
      ew  = hmem_rsp_valid;
      ei  = ew ? 3'(c / 2 - 1) : 3'd0;
      exp = {c <= 17, c == 17, ev, ea, ew, ei, c == 2};
      got = {b_busy, b_done, b_valid, b_addr, b_wr_en, b_wr_idx, b_crit_valid};
      n_checks++;
      if (got !== exp) $display("FAIL no_cwf c=%0d: got %h, want %h", c, got, exp);
      else n_pass++;
      if (a_wr_en || a_busy) n_a_wr++;
      tick();
    end
    n_checks++;
    if (n_a_wr !== 0) $display("FAIL idle_ignores_rsp: got %0d active cycles, want 0", n_a_wr);
    else n_pass++;
  endtask

  // Victim block 0x7F -> writes to 0xFE0..0xFFC, then the fill of 0x1000.
  task automatic test_dirty_writeback();
    logic [70:0] got, exp;
    logic [2:0]  got3, exp3;
    int          n_cwb = 0;
    clear_inputs();
    fill_addr    = 32'h1014;
    victim_block = 27'h7F;
    victim_dirty = 1'b1;
    start_a      = 1'b1;
    tick();
    for (int c = 1; c <= 9; c++) begin
      clear_inputs();
      line_rd_word = 32'h5500_0000 + 32'(c);
      #1;
      if (c <= 8)
        exp = {1'b1, 1'b1, 1'b1, 32'hFE0 + 32'((c - 1) * 4), 3'(c - 1), line_rd_word, c == 8};
      else
        exp = {1'b1, 1'b1, 1'b0, 32'h1014, 3'd0, 32'h0, 1'b0};
      got = {a_busy, a_valid, a_write, a_addr, a_rd_idx, a_store, a_count_wb};
      n_checks++;
      if (got !== exp) $display("FAIL writeback c=%0d: got %h, want %h", c, got, exp);
      else n_pass++;
      if (a_count_wb) n_cwb++;
      tick();
    end
    for (int c = 10; c <= 26; c++) begin
      clear_inputs();
      hmem_rsp_valid = ((c - 8) % 2 == 0) && (c - 8 <= 16);
      hmem_rsp_word  = 32'hC000_0000 + 32'(c);
      #1;
      exp3 = {c <= 25, c == 25, 1'b0};
      got3 = {a_busy, a_done, a_count_wb};
      n_checks++;
      if (got3 !== exp3) $display("FAIL wb_fill c=%0d: got %b, want %b", c, got3, exp3);
      else n_pass++;
      if (a_count_wb) n_cwb++;
      tick();
    end
    n_checks++;
    if (n_cwb !== 1) $display("FAIL count_writeback: got %0d pulses, want 1", n_cwb);
    else n_pass++;
  endtask

  // Beat 2 stalled 3 cycles with a stray response and a start while busy in the stall;
  // start in the DONE cycle is ignored, the next one is taken.
  task automatic test_backpressure();
    logic [38:0] got, exp;
    logic [33:0] got2;
    logic [31:0] ea;
    logic [2:0]  ei;
    logic        ev, ew;
    int          k;
    int          n_wr = 0;
    clear_inputs();
    fill_addr = 32'h1014;
    start_a   = 1'b1;
    tick();
    for (int c = 1; c <= 21; c++) begin
      clear_inputs();
      hmem_req_ready = !(c >= 3 && c <= 5);
      ew = (c == 2) || (c >= 7 && c <= 19 && c % 2 == 1);
      hmem_rsp_valid = ew || (c == 4);
      hmem_rsp_word  = 32'hD000_0000 + 32'(c);
      if (c == 4) begin
        start_a   = 1'b1;
        fill_addr = 32'h2000;
      end
      if (c == 20 || c == 21) begin
        start_a   = 1'b1;
        fill_addr = 32'h3000;
      end
      #1;
      ev = (c == 1) || (c >= 3 && c <= 6) || (c >= 8 && c <= 18 && c % 2 == 0);
      k  = (c == 1) ? 1 : (c <= 6) ? 2 : (c - 2) / 2;
      ea = ev ? 32'h1000 + 32'(((5 + k - 1) % 8) * 4) : 32'h0;
      k  = (c == 2) ? 1 : (c - 3) / 2;
      ei = ew ? 3'((5 + k - 1) % 8) : 3'd0;
      exp = {c <= 20, c == 20, ev, ea, ew, ei};
      got = {a_busy, a_done, a_valid, a_addr, a_wr_en, a_wr_idx};
      n_checks++;
      if (got !== exp) $display("FAIL backpressure c=%0d: got %h, want %h", c, got, exp);
      else n_pass++;
      if (a_wr_en) n_wr++;
      tick();
    end
    clear_inputs();
    #1;
    got2 = {a_busy, a_valid, a_addr};
    n_checks++;
    if (got2 !== {1'b1, 1'b1, 32'h3000})
      $display("FAIL restart_after_done: got %h, want 3_00003000", got2);
    else n_pass++;
    n_checks++;
    if (n_wr !== 8) $display("FAIL beat_count: got %0d beats, want 8", n_wr);
    else n_pass++;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_fill();
    logic [139:0] got;
    logic [33:0]  got2;
    clear_inputs();
    fill_addr = 32'h1014;
    start_a   = 1'b1;
    tick();
    for (int c = 1; c <= 10; c++) begin
      clear_inputs();
      hmem_rsp_valid = (c % 2 == 0) && (c <= 8);
      hmem_rsp_word  = 32'hE000_0000 + 32'(c);
      if (c == 10) reset_n = 1'b0;
      #1;
      if (c >= 9) begin
        got2 = {a_busy, a_valid, a_addr};
        n_checks++;
        if (got2 !== ((c == 9) ? {1'b1, 1'b1, 32'h1004} : {1'b1, 1'b0, 32'h0}))
          $display("FAIL mid_fill c=%0d: got %h", c, got2);
        else n_pass++;
      end
      tick();
    end
    reset_n = 1'b1;
    for (int c = 11; c <= 12; c++) begin
      clear_inputs();
      hmem_rsp_valid = 1'b1;
      hmem_rsp_word  = 32'h1234_5678;
      line_rd_word   = 32'hCAFE_F00D;
      #1;
      got = {a_busy, a_done, a_valid, a_write, a_addr, a_store, a_rd_idx, a_wr_en, a_wr_idx,
             a_wr_word, a_crit_valid, a_crit_word, a_count_wb};
      n_checks++;
      if (got !== '0) $display("FAIL reset_abandon c=%0d: got %h, want 0", c, got);
      else n_pass++;
      tick();
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_clean_fill();
    test_no_cwf();
    test_dirty_writeback();
    test_backpressure();
    test_reset_mid_fill();
    test_clean_fill();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
